// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter with valid/ready flow control on both sides.
// Optional macro GRAY_ERR_CHECK_EN adds out_err (Gray input Hamming-distance check).
module gray_codec_pipe #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_mode
`ifdef GRAY_ERR_CHECK_EN
  ,
  output logic         out_err
`endif
);

  logic                      adv;
  logic                      acc;
  logic [N-1:0]              conv;
  logic [STAGES-1:0]         vld_q, vld_d;
  logic [STAGES-1:0]         mode_q, mode_d;
  logic [STAGES-1:0][N-1:0]  data_q, data_d;

  // Handshake: input transfers on in_valid & in_ready, output on out_valid & out_ready;
  // the whole pipe shifts in lockstep whenever the last stage is empty or being drained.
  assign adv      = out_ready | ~vld_q[STAGES-1];
  assign in_ready = adv;

  always_comb begin
    acc  = 1'b0;
    conv = in_data ^ (in_data >> 1);
    if (!in_mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        acc     = acc ^ in_data[i];
        conv[i] = acc;
      end
    end
  end

`ifdef GRAY_ERR_CHECK_EN
  logic [STAGES-1:0] err_q, err_d;
  logic [N-1:0]      prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic              err_new;

  always_comb begin
    err_new     = have_prev_q && ($countones(in_data ^ prev_q) != 1);
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (in_valid && adv && !in_mode) begin
      prev_d      = in_data;
      have_prev_d = 1'b1;
    end
  end

  assign out_err = err_q[STAGES-1];
`endif

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    data_d = data_q;
`ifdef GRAY_ERR_CHECK_EN
    err_d  = err_q;
`endif
    if (adv) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = conv;
        mode_d[0] = in_mode;
`ifdef GRAY_ERR_CHECK_EN
        err_d[0]  = ~in_mode & err_new;
`endif
      end
      // Bubbles shift through, but an empty stage keeps its old data.
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) begin
          data_d[s] = data_q[s-1];
          mode_d[s] = mode_q[s-1];
`ifdef GRAY_ERR_CHECK_EN
          err_d[s]  = err_q[s-1];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q       <= '0;
      mode_q      <= '0;
      data_q      <= '0;
`ifdef GRAY_ERR_CHECK_EN
      err_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
`endif
    end else begin
      vld_q       <= vld_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
`ifdef GRAY_ERR_CHECK_EN
      err_q       <= err_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
`endif
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: directed steps plus random traffic against a behavioural model.
// Checks out_err too when GRAY_ERR_CHECK_EN is defined.
module tb_gray_codec_pipe;
  localparam int N      = 8;
  localparam int STAGES = 2;
  localparam int W      = N + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         out_mode;
`ifdef GRAY_ERR_CHECK_EN
  logic         out_err;
`endif

  gray_codec_pipe #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
`ifdef GRAY_ERR_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_q[$];
  logic         mv[STAGES];
  logic         hold_pending = 1'b0;
  logic [N-1:0] held_data;
  logic         held_mode;
  logic         seen_ov;
  logic [N-1:0] prev_g;
  logic         have_prev = 1'b0;
  int           lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = g;
    for (int s = 1; s < N; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int hamming(input logic [N-1:0] a, input logic [N-1:0] b);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (a[i] != b[i]) c++;
    return c;
  endfunction

  task automatic push_model(input logic [N-1:0] d, input logic m);
    logic [W-1:0] e;
    e = '0;
    if (m) begin
      e[N-1:0] = d ^ (d >> 1);
    end else begin
      e[N-1:0] = ref_g2b(d);
      e[N+1]   = have_prev && (hamming(d, prev_g) != 1);
      prev_g    = d;
      have_prev = 1'b1;
    end
    e[N] = m;
    exp_q.push_back(e);
  endtask

  // driver: one cycle of stimulus, observed mid-cycle
  task automatic drive(input logic v, input logic [N-1:0] d, input logic m, input logic r);
    logic         exp_ov;
    logic         exp_adv;
    logic [W-1:0] e;
    @(negedge clk);
    in_valid = v; in_data = d; in_mode = m; out_ready = r;
    #1;
    exp_ov  = mv[STAGES-1];
    exp_adv = r | ~exp_ov;
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_adv);
    if (hold_pending) begin
      chk("hold_data", out_data, held_data);
      chk("hold_mode", out_mode, held_mode);
    end
    hold_pending = out_valid && !r;
    held_data    = out_data;
    held_mode    = out_mode;
    seen_ov      = out_valid;
    if (exp_ov && r) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[N-1:0]);
        chk("out_mode", out_mode, e[N]);
`ifdef GRAY_ERR_CHECK_EN
        chk("out_err", out_err, e[N+1]);
`endif
      end
    end
    if (exp_adv) begin
      for (int s = STAGES - 1; s > 0; s--) mv[s] = mv[s-1];
      mv[0] = v;
      if (v) push_model(d, m);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mode", out_mode, 0);
`ifdef GRAY_ERR_CHECK_EN
    chk("rst_out_err", out_err, 0);
`endif
    reset = 1'b1;
    exp_q.delete();
    for (int s = 0; s < STAGES; s++) mv[s] = 1'b0;
    hold_pending = 1'b0;
    have_prev    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int s = 0; s < STAGES; s++) mv[s] = 1'b0;
    do_reset();
    @(negedge clk);
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // latency of a lone word through an empty pipe
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      if (seen_ov && lat == 0) lat = i;
    end
    chk("latency", lat, STAGES);

    // consecutive Gray->binary words 001, 101, 110
    drive(1'b1, 8'b001, 1'b0, 1'b1);
    drive(1'b1, 8'b101, 1'b0, 1'b1);
    drive(1'b1, 8'b110, 1'b0, 1'b1);
    idle(STAGES + 2);

    // binary->Gray 110, 100
    drive(1'b1, 8'b110, 1'b1, 1'b1);
    drive(1'b1, 8'b100, 1'b1, 1'b1);
    idle(STAGES + 2);

    // alternating modes on the same word
    drive(1'b1, 8'h5A, 1'b0, 1'b1);
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    idle(STAGES + 2);

    // backpressure: fill, stall four cycles, then drain
    for (int i = 0; i < STAGES + 4; i++) drive(1'b1, N'(8'h30 + i), i[0], 1'b0);
    idle(STAGES + 3);

    // reset with words in flight, then a fresh word
    drive(1'b1, 8'hA3, 1'b0, 1'b1);
    drive(1'b1, 8'h47, 1'b1, 1'b1);
    do_reset();
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    idle(STAGES + 2);

    // Gray sequence for the distance check: 000, 001, 111, 110
    do_reset();
    drive(1'b1, 8'b000, 1'b0, 1'b1);
    drive(1'b1, 8'b001, 1'b0, 1'b1);
    drive(1'b1, 8'b111, 1'b0, 1'b1);
    drive(1'b1, 8'b110, 1'b0, 1'b1);
    idle(STAGES + 2);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end
    idle(STAGES + 4);
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
Parametrised, pipelined successor to the single-mode Gray-to-binary converter. Converts N-bit words in either direction (Gray->binary or binary->Gray), selected per transaction. Uses valid/ready handshakes on both sides with STAGES-deep backpressurable pipelining. Sits between Gray-coded counter/pointer sources (CDC pointers, encoders) and binary consumers, or the reverse.

Parameters:
N, 8, data width in bits (N >= 2)
STAGES, 2, pipeline depth in register stages (1..4); also the latency in cycles

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  N  word to convert
in_mode  input  1  0 = Gray->binary, 1 = binary->Gray
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts output this cycle
out_data  output  N  converted word
out_mode  output  1  in_mode that accompanied this word

Behaviour:
- Reset (reset=0 at a rising edge): every stage valid bit cleared. out_valid=0, out_data=0, out_mode=0. in_ready=1 on the first cycle after reset deasserts. Reset mid-operation discards all in-flight words; there is no partial drain.
- Transfer rules: input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Advance signal: adv = out_ready | ~out_valid. All stages shift together when adv=1 and hold when adv=0.
- in_ready = adv, combinational from out_ready and the last-stage valid. There is no bubble collapsing; a bubble inside the pipe does not raise in_ready while the output stalls.
- Stage 1 registers the conversion result, so stages 2..STAGES are pure delay.
  - Gray->binary: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i] for i=N-2..0.
  - Binary->Gray: g = b ^ (b>>1).
- Latency: a word accepted at edge t appears with out_valid=1 after edge t+STAGES-1, provided adv stays 1. With STAGES=1, the output is registered one edge after acceptance.
- Throughput: 1 word/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out_data, out_mode and out_valid are held stable. Every stage holds, and no input is accepted.
- Simultaneous output transfer and input accept in one cycle is legal and loses no word.
- in_data and in_mode are ignored when in_valid=0. A stage with valid=0 keeps its data register unchanged.
- Mode may change every transaction; each word carries its own mode through the pipe.

Optional Feature:
GRAY_ERR_CHECK_EN
- Defined:
  - Adds output out_err (1 bit), pipelined alongside out_data.
  - For each accepted Gray->binary word, out_err=1 if its Hamming distance from the previous accepted Gray->binary word is not exactly 1.
  - The first Gray->binary word after reset always has out_err=0.
  - Binary->Gray words have out_err=0 and do not update the previous-word register.
  - out_err resets to 0. Both the previous-word register and its first-word flag clear on reset.
- Undefined: no out_err port and no comparison logic. All other behaviour is identical.

Test Plan:
- N=3, STAGES=2, mode=0, out_ready=1, inputs 001, 101, 110 on consecutive cycles -> out_data 001, 110, 100 on consecutive cycles, first one 2 edges after the first accept.
- N=3, mode=1, inputs 110, 100 -> out_data 101, 110; out_mode=1 on both.
- Backpressure: out_ready=0 for 4 cycles with the pipe full -> in_ready=0, out_data held constant. On out_ready=1, the words drain in order with no loss or duplication.
- Alternating mode per word (N=8): 0x5A g2b, 0x5A b2g -> 0x6C (mode 0) then 0x77 (mode 1).
- Reset asserted with 2 words in flight -> next cycle out_valid=0, out_data=0. After release, a new word 0x01 (g2b) -> 0x01 with no stale outputs.
- GRAY_ERR_CHECK_EN, N=3, g2b inputs 000, 001, 111, 110 -> out_err 0, 0, 1, 0.
